// File: rtl/tone_sequencer_if.sv
// Note-command channel between the melody reader and the tone sequencer.
interface tone_sequencer_if;
   logic        note_valid;
   logic        note_ready;
   logic [3:0]  note_code;
   logic [15:0] note_ms;

   // Command producer (melody ROM reader / control FSM)
   modport master (
      output note_valid,
      output note_code,
      output note_ms,
      input  note_ready
   );

   // Command consumer (tone sequencer)
   modport slave (
      input  note_valid,
      input  note_code,
      input  note_ms,
      output note_ready
   );
endinterface

// File: rtl/tone_sequencer.sv
// Tone sequencer: turns note commands into divide counts for the clock divider,
// times each note in ms ticks and follows it with a fixed silent gap.
module tone_sequencer #(
   parameter int unsigned TICKS_PER_MS = 50000,
   parameter int unsigned GAP_MS       = 10
) (
   input  logic              inclk,
   input  logic              Reset,
   tone_sequencer_if.slave   cmd,
   output logic [31:0]       div_clk_count,
   output logic              div_reset,
   output logic              busy
);

   localparam int unsigned PRESC_W   = $clog2(TICKS_PER_MS);
   localparam int unsigned MS_W      = 16;
   localparam int unsigned CNT_W     = 32;
   localparam logic [CNT_W-1:0] RESET_COUNT = 32'd95556;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
   logic [MS_W-1:0]    note_ms_q, note_ms_d;
   logic [CNT_W-1:0]   div_clk_count_q, div_clk_count_d;
   logic               div_reset_q, div_reset_d;
   logic               note_ready_q, note_ready_d;
   logic               busy_q, busy_d;

   logic               accept_c;
   logic               tick_c;
   logic [MS_W:0]      ms_next_c;

   // Note code to divide count (50 MHz, divider period = 2*count)
   function automatic logic [CNT_W-1:0] note_count(input logic [2:0] code);
      logic [CNT_W-1:0] cnt;
      case (code)
         3'd0:    cnt = 32'd95556;
         3'd1:    cnt = 32'd85131;
         3'd2:    cnt = 32'd75843;
         3'd3:    cnt = 32'd71586;
         3'd4:    cnt = 32'd63776;
         3'd5:    cnt = 32'd56818;
         3'd6:    cnt = 32'd50619;
         default: cnt = 32'd47778;
      endcase
      return cnt;
   endfunction

   // Handshake, ms-tick detection and the one-ahead ms count (17 bits so 16'hFFFF never wraps)
   always_comb begin
      accept_c  = cmd.note_valid && note_ready_q;
      tick_c    = (CNT_W'(presc_q) == CNT_W'(TICKS_PER_MS - 1));
      ms_next_c = (MS_W+1)'(ms_cnt_q) + (MS_W+1)'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d         = state_q;
      presc_d         = presc_q;
      ms_cnt_d        = ms_cnt_q;
      note_ms_d       = note_ms_q;
      div_clk_count_d = div_clk_count_q;
      div_reset_d     = div_reset_q;

      case (state_q)
         ST_IDLE: begin
            div_reset_d = 1'b1;
            if (accept_c) begin
               note_ms_d = cmd.note_ms;
               presc_d   = '0;
               ms_cnt_d  = '0;
               if (cmd.note_ms == '0) begin
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_PLAY;
                  // Rests leave the divider silenced and its count untouched
                  if (!cmd.note_code[3]) begin
                     div_clk_count_d = note_count(cmd.note_code[2:0]);
                     div_reset_d     = 1'b0;
                  end
               end
            end
         end

         ST_PLAY: begin
            if (tick_c) begin
               presc_d = '0;
               if (ms_next_c == (MS_W+1)'(note_ms_q)) begin
                  state_d     = ST_GAP;
                  ms_cnt_d    = '0;
                  div_reset_d = 1'b1;
               end else begin
                  ms_cnt_d = ms_next_c[MS_W-1:0];
               end
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
         end

         ST_GAP: begin
            div_reset_d = 1'b1;
            if (GAP_MS == 0) begin
               state_d = ST_IDLE;
            end else if (tick_c) begin
               presc_d = '0;
               if (CNT_W'(ms_next_c) == CNT_W'(GAP_MS)) begin
                  state_d  = ST_IDLE;
                  ms_cnt_d = '0;
               end else begin
                  ms_cnt_d = ms_next_c[MS_W-1:0];
               end
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
         end

         default: begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            ms_cnt_d    = '0;
            div_reset_d = 1'b1;
         end
      endcase

      note_ready_d = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers, synchronous active-high reset
   always_ff @(posedge inclk) begin
      if (Reset) begin
         state_q         <= ST_IDLE;
         presc_q         <= '0;
         ms_cnt_q        <= '0;
         note_ms_q       <= '0;
         div_clk_count_q <= RESET_COUNT;
         div_reset_q     <= 1'b1;
         note_ready_q    <= 1'b1;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         presc_q         <= presc_d;
         ms_cnt_q        <= ms_cnt_d;
         note_ms_q       <= note_ms_d;
         div_clk_count_q <= div_clk_count_d;
         div_reset_q     <= div_reset_d;
         note_ready_q    <= note_ready_d;
         busy_q          <= busy_d;
      end
   end

   assign cmd.note_ready = note_ready_q;
   assign div_clk_count  = div_clk_count_q;
   assign div_reset      = div_reset_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICKS_PER_MS = 4, GAP_MS = 2.
module tb_tone_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] div_clk_count;
   logic        div_reset;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] ms;
      logic [31:0] exp_count;
      int          exp_busy;
      int          exp_low;
   } vec_t;

   vec_t vecs[8];

   tone_sequencer_if cmd();

   tone_sequencer #(
      .TICKS_PER_MS (4),
      .GAP_MS       (2)
   ) dut (
      .inclk         (clk),
      .Reset         (rst),
      .cmd           (cmd),
      .div_clk_count (div_clk_count),
      .div_reset     (div_reset),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Send one command and measure busy length, div_reset-low length and count stability
   task automatic run_note(input string tag, input logic [3:0] code, input logic [15:0] ms,
                           input logic [31:0] exp_count, input int exp_busy, input int exp_low);
      int          guard;
      int          busy_n;
      int          low_n;
      logic [31:0] held;
      logic        changed;
      guard = 0;
      while (!cmd.note_ready && guard < 100) begin
         step();
         guard++;
      end
      chk({tag, " ready_before"}, 32'(cmd.note_ready), 32'd1);
      cmd.note_valid = 1'b1;
      cmd.note_code  = code;
      cmd.note_ms    = ms;
      step();
      cmd.note_valid = 1'b0;
      cmd.note_code  = 4'd0;
      cmd.note_ms    = 16'd7;
      chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      chk({tag, " ready_after_accept"}, 32'(cmd.note_ready), 32'd0);
      chk({tag, " count_after_accept"}, div_clk_count, exp_count);
      chk({tag, " div_reset_after_accept"}, 32'(div_reset), (exp_low != 0) ? 32'd0 : 32'd1);
      busy_n  = 0;
      low_n   = 0;
      held    = div_clk_count;
      changed = 1'b0;
      guard   = 0;
      while (busy && guard < 500) begin
         busy_n++;
         if (!div_reset) low_n++;
         if (div_clk_count !== held) changed = 1'b1;
         step();
         guard++;
      end
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      chk({tag, " div_reset_low_cycles"}, 32'(low_n), 32'(exp_low));
      chk({tag, " count_changed"}, 32'(changed), 32'd0);
      chk({tag, " ready_at_end"}, 32'(cmd.note_ready), 32'd1);
      chk({tag, " div_reset_at_end"}, 32'(div_reset), 32'd1);
      chk({tag, " count_at_end"}, div_clk_count, exp_count);
   endtask

   initial begin
      int guard;
      int busy_n;

      vecs[0] = '{code: 4'd5,  ms: 16'd3, exp_count: 32'd56818, exp_busy: 20, exp_low: 12};
      vecs[1] = '{code: 4'd9,  ms: 16'd2, exp_count: 32'd56818, exp_busy: 16, exp_low: 0};
      vecs[2] = '{code: 4'd2,  ms: 16'd0, exp_count: 32'd56818, exp_busy: 8,  exp_low: 0};
      vecs[3] = '{code: 4'd0,  ms: 16'd1, exp_count: 32'd95556, exp_busy: 12, exp_low: 4};
      vecs[4] = '{code: 4'd6,  ms: 16'd2, exp_count: 32'd50619, exp_busy: 16, exp_low: 8};
      vecs[5] = '{code: 4'd15, ms: 16'd1, exp_count: 32'd50619, exp_busy: 12, exp_low: 0};
      vecs[6] = '{code: 4'd1,  ms: 16'd1, exp_count: 32'd85131, exp_busy: 12, exp_low: 4};
      vecs[7] = '{code: 4'd3,  ms: 16'd2, exp_count: 32'd71586, exp_busy: 16, exp_low: 8};

      // Reset held for three cycles
      rst            = 1'b1;
      cmd.note_valid = 1'b0;
      cmd.note_code  = 4'd0;
      cmd.note_ms    = 16'd0;
      repeat (3) step();
      rst = 1'b0;
      chk("reset note_ready", 32'(cmd.note_ready), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset div_reset", 32'(div_reset), 32'd1);
      chk("reset div_clk_count", div_clk_count, 32'd95556);

      // Table of single notes, rests and zero-length notes
      for (int i = 0; i < 8; i++) begin
         run_note($sformatf("vec%0d", i), vecs[i].code, vecs[i].ms,
                  vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_low);
      end

      // Back-to-back: valid held high, second command waits for the first gap to finish
      cmd.note_valid = 1'b1;
      cmd.note_code  = 4'd0;
      cmd.note_ms    = 16'd1;
      step();
      chk("b2b first busy", 32'(busy), 32'd1);
      chk("b2b first count", div_clk_count, 32'd95556);
      cmd.note_code = 4'd7;
      cmd.note_ms   = 16'd1;
      busy_n = 0;
      guard  = 0;
      while (busy && guard < 100) begin
         busy_n++;
         step();
         guard++;
      end
      chk("b2b first busy_cycles", 32'(busy_n), 32'd12);
      chk("b2b ready between", 32'(cmd.note_ready), 32'd1);
      step();
      cmd.note_valid = 1'b0;
      chk("b2b second busy", 32'(busy), 32'd1);
      chk("b2b second count", div_clk_count, 32'd47778);
      chk("b2b second div_reset", 32'(div_reset), 32'd0);
      busy_n = 0;
      guard  = 0;
      while (busy && guard < 100) begin
         busy_n++;
         step();
         guard++;
      end
      chk("b2b second busy_cycles", 32'(busy_n), 32'd12);
      repeat (3) step();
      chk("b2b no extra accept", 32'(busy), 32'd0);

      // Reset in the fifth PLAY cycle of a 12-cycle note
      cmd.note_valid = 1'b1;
      cmd.note_code  = 4'd4;
      cmd.note_ms    = 16'd3;
      step();
      cmd.note_valid = 1'b0;
      chk("midreset count before", div_clk_count, 32'd63776);
      repeat (4) step();
      chk("midreset div_reset before", 32'(div_reset), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset note_ready", 32'(cmd.note_ready), 32'd1);
      chk("midreset div_reset", 32'(div_reset), 32'd1);
      chk("midreset div_clk_count", div_clk_count, 32'd95556);
      run_note("after_reset", 4'd1, 16'd3, 32'd85131, 20, 12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
